// File: rtl/led_fsm_pkg.sv
// rtl/led_fsm_pkg.sv - shared types, constants and level helper for the VU meter
package led_fsm_pkg;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    UPDATE = 1'b1
  } state_t;

  localparam int LED_COUNT = 8;
  localparam int LVL_W     = 4;
  localparam int LVL_SHIFT = 4;
  localparam int LVL_ROUND = 15;

  // Ceiling-style bucket: 0 -> 0, 1..16 -> 1, ..., 113..127 -> 8.
  function automatic logic [LVL_W-1:0] lvl_of(input logic [6:0] m);
    logic [7:0] s;
    s = {1'b0, m} + 8'(LVL_ROUND);
    return s[LVL_SHIFT +: LVL_W];
  endfunction

endpackage

// File: rtl/led_level_enc.sv
// rtl/led_level_enc.sv - signed sample to saturated magnitude and bar level
module led_level_enc
  import led_fsm_pkg::*;
(
  input  logic [7:0]       sample,
  output logic [6:0]       mag,
  output logic [LVL_W-1:0] lvl
);

  always_comb begin
    mag = sample[6:0];
    // -128 has no positive 8-bit counterpart, so it clamps to full scale.
    if (sample == 8'h80)
      mag = 7'd127;
    else if (sample[7])
      mag = 7'(~sample[6:0] + 7'd1);
    lvl = lvl_of(mag);
  end

endmodule

// File: rtl/led_fsm.sv
// rtl/led_fsm.sv - peak-hold audio level meter driving an 8-LED thermometer bar
module led_fsm
  import led_fsm_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           audio_in,
  output logic [LED_COUNT-1:0] led
);

  localparam int             CW       = $clog2(WINDOW);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WINDOW - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [6:0]           peak;
  logic [6:0]           mag;
  logic [6:0]           pk_mag_unused;
  logic [LVL_W-1:0]     in_lvl_unused;
  logic [LVL_W-1:0]     pk_lvl;
  logic [LVL_W-1:0]     disp;
  logic [LVL_W-1:0]     disp_next;
  logic [LED_COUNT-1:0] therm;

  led_level_enc u_enc_in (
    .sample (audio_in),
    .mag    (mag),
    .lvl    (in_lvl_unused)
  );

  led_level_enc u_enc_peak (
    .sample ({1'b0, peak}),
    .mag    (pk_mag_unused),
    .lvl    (pk_lvl)
  );

  always_comb begin
    disp_next = disp;
    if (pk_lvl >= disp)
      disp_next = pk_lvl;
    else
      disp_next = disp - LVL_W'(1);  // pk_lvl < disp implies disp > 0
    therm = '0;
    for (int i = 0; i < LED_COUNT; i++)
      therm[i] = (LVL_W'(i) < disp_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      cnt   <= '0;
      peak  <= '0;
      disp  <= '0;
      led   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (mag > peak)
            peak <= mag;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        UPDATE: begin
          disp  <= disp_next;
          led   <= therm;
          peak  <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fsm.sv
// tb/tb_led_fsm.sv - table-driven bench for the VU meter
module tb_led_fsm;
  import led_fsm_pkg::*;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] audio_in;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;
  logic [7:0] cur;

  typedef struct {
    logic [7:0] smp;
    logic [7:0] upd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[23];

  led_fsm #(.WINDOW(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .audio_in (audio_in),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic run_window(input string name, input logic [7:0] smp, input logic [7:0] upd,
                            input logic [7:0] exp);
    for (int c = 0; c < W; c++) begin
      audio_in = smp;
      @(posedge clk); #1;
      check({name, "_hold"}, 32'(led), 32'(cur));
    end
    audio_in = upd;
    @(posedge clk); #1;
    check(name, 32'(led), 32'(exp));
    cur = exp;
  endtask

  task automatic window_spike(input string name, input int pos, input logic [7:0] exp);
    for (int c = 0; c < W; c++) begin
      audio_in = (c == pos) ? 8'h7F : 8'h00;
      @(posedge clk); #1;
      check({name, "_hold"}, 32'(led), 32'(cur));
    end
    audio_in = 8'h00;
    @(posedge clk); #1;
    check(name, 32'(led), 32'(exp));
    cur = exp;
  endtask

  initial begin
    vecs[0]  = '{8'h01, 8'h00, 8'h01};
    vecs[1]  = '{8'h12, 8'h00, 8'h03};
    vecs[2]  = '{8'h00, 8'h00, 8'h01};
    vecs[3]  = '{8'h00, 8'h00, 8'h00};
    vecs[4]  = '{8'hE0, 8'h00, 8'h03};
    vecs[5]  = '{8'h80, 8'h00, 8'hFF};
    vecs[6]  = '{8'h00, 8'h00, 8'h7F};
    vecs[7]  = '{8'h00, 8'h00, 8'h3F};
    vecs[8]  = '{8'h00, 8'h00, 8'h1F};
    vecs[9]  = '{8'h00, 8'h00, 8'h0F};
    vecs[10] = '{8'h00, 8'h00, 8'h07};
    vecs[11] = '{8'h00, 8'h00, 8'h03};
    vecs[12] = '{8'h00, 8'h00, 8'h01};
    vecs[13] = '{8'h00, 8'h00, 8'h00};
    vecs[14] = '{8'h00, 8'h00, 8'h00};
    vecs[15] = '{8'hF2, 8'h00, 8'h01};
    vecs[16] = '{8'h10, 8'h00, 8'h01};
    vecs[17] = '{8'h11, 8'h00, 8'h03};
    vecs[18] = '{8'h71, 8'h00, 8'hFF};
    vecs[19] = '{8'h70, 8'h00, 8'h7F};
    vecs[20] = '{8'h70, 8'h00, 8'h7F};
    vecs[21] = '{8'h70, 8'h7F, 8'h7F};
    vecs[22] = '{8'h00, 8'h00, 8'h3F};

    reset    = 1'b1;
    audio_in = 8'h7F;
    cur      = 8'h00;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("reset_led", 32'(led), 32'h00);
      check("reset_cnt", 32'(dut.cnt), 32'd0);
      check("reset_state", 32'(dut.state), 32'(ACCUM));
    end
    reset = 1'b0;

    for (int i = 0; i < 23; i++)
      run_window($sformatf("vec%0d", i), vecs[i].smp, vecs[i].upd, vecs[i].exp);

    window_spike("spike_mid", 7, 8'hFF);
    run_window("decay_a", 8'h00, 8'h00, 8'h7F);
    window_spike("spike_last", W - 1, 8'hFF);
    run_window("decay_b", 8'h00, 8'h00, 8'h7F);
    window_spike("spike_first", 0, 8'hFF);

    for (int c = 0; c < W / 2; c++) begin
      audio_in = 8'h7F;
      @(posedge clk); #1;
      check("pre_rst_hold", 32'(led), 32'(cur));
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_led", 32'(led), 32'h00);
    check("rst_mid_cnt", 32'(dut.cnt), 32'd0);
    cur = 8'h00;
    run_window("rst_mid_win", 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
